// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: shared MDU op codes, default latencies and FSM state type
package mdu_ctrl_pkg;
  localparam logic [3:0] MDU_NOP   = 4'd0;
  localparam logic [3:0] MDU_MULT  = 4'd1;
  localparam logic [3:0] MDU_MULTU = 4'd2;
  localparam logic [3:0] MDU_DIV   = 4'd3;
  localparam logic [3:0] MDU_DIVU  = 4'd4;
  localparam logic [3:0] MDU_MFHI  = 4'd5;
  localparam logic [3:0] MDU_MFLO  = 4'd6;
  localparam logic [3:0] MDU_MTHI  = 4'd7;
  localparam logic [3:0] MDU_MTLO  = 4'd8;
  localparam int MDU_MULT_CYCLES = 5;
  localparam int MDU_DIV_CYCLES  = 10;
  typedef enum logic [1:0] {IDLE, MUL, DIV} state_e;
  function automatic logic is_mul(input logic [3:0] op);
    return op == MDU_MULT || op == MDU_MULTU;
  endfunction
  function automatic logic is_div(input logic [3:0] op);
    return op == MDU_DIV || op == MDU_DIVU;
  endfunction
endpackage

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: E-stage request and HI/LO result bundle of the MDU controller
interface mdu_ctrl_if #(parameter int WIDTH = 32);
  logic             start;
  logic [3:0]       op;
  logic [WIDTH-1:0] rs_val;
  logic [WIDTH-1:0] rt_val;
  logic             flush;
  logic             d_md_use;
  logic             busy;
  logic             stall;
  logic [WIDTH-1:0] mf_out;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  modport master (output start, op, rs_val, rt_val, flush, d_md_use,
                  input  busy, stall, mf_out, hi, lo);
  modport slave  (input  start, op, rs_val, rt_val, flush, d_md_use,
                  output busy, stall, mf_out, hi, lo);
endinterface

// File: rtl/mdu_arith.sv
// mdu_arith: combinational signed/unsigned multiply and divide datapath
module mdu_arith
  import mdu_ctrl_pkg::*;
#(parameter int WIDTH = 32) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] res_hi,
  output logic [WIDTH-1:0] res_lo,
  output logic             div0
);
  logic zero_b;
  logic [WIDTH-1:0] bs, uq, ur;
  logic signed [WIDTH-1:0] sq, sr;
  logic signed [2*WIDTH-1:0] sp;
  logic [2*WIDTH-1:0] up;
  assign zero_b = b == '0;
  // a zero divisor is replaced by 1 so the divider never produces X; the result is discarded anyway
  assign bs = zero_b ? WIDTH'(1) : b;
  assign sp = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
  assign up = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
  assign sq = $signed(a) / $signed(bs);
  assign sr = $signed(a) % $signed(bs);
  assign uq = a / bs;
  assign ur = a % bs;
  assign div0 = is_div(op) & zero_b;
  // select the HI/LO pair for the requested operation
  always_comb begin
    res_hi = op == MDU_MULT  ? sp[2*WIDTH-1:WIDTH] :
             op == MDU_MULTU ? up[2*WIDTH-1:WIDTH] :
             op == MDU_DIV   ? sr :
             op == MDU_DIVU  ? ur : '0;
    res_lo = op == MDU_MULT  ? sp[WIDTH-1:0] :
             op == MDU_MULTU ? up[WIDTH-1:0] :
             op == MDU_DIV   ? sq :
             op == MDU_DIVU  ? uq : '0;
  end
endmodule

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: MDU sequencing FSM, busy counter, HI/LO registers and D-stage stall
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = MDU_MULT_CYCLES,
  parameter int DIV_CYCLES  = MDU_DIV_CYCLES
) (
  input logic       clk,
  input logic       reset,
  mdu_ctrl_if.slave bus
);
  state_e state, next_state;
  logic [3:0] cnt;
  logic [WIDTH-1:0] hi_q, lo_q, temp_hi, temp_lo, res_hi, res_lo;
  logic temp_div0, div0, idle, accept, commit;
  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .op(bus.op), .a(bus.rs_val), .b(bus.rt_val),
    .res_hi(res_hi), .res_lo(res_lo), .div0(div0)
  );
  assign idle   = state == IDLE;
  assign accept = bus.start & ~bus.flush & idle & (is_mul(bus.op) | is_div(bus.op));
  assign commit = ~idle & (cnt == 4'd1);
  // next state: accepted start launches, last busy cycle returns to IDLE
  always_comb begin
    next_state = accept ? (is_mul(bus.op) ? MUL : DIV) : commit ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end
  // latch operands' result and latency on accept, count down while busy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt       <= '0;
      temp_hi   <= '0;
      temp_lo   <= '0;
      temp_div0 <= 1'b0;
    end else if (accept) begin
      cnt       <= is_mul(bus.op) ? 4'(MULT_CYCLES) : 4'(DIV_CYCLES);
      temp_hi   <= res_hi;
      temp_lo   <= res_lo;
      temp_div0 <= div0;
    end else if (!idle) begin
      cnt <= cnt - 4'd1;
    end
  end
  // HI/LO: commit finished result (not on divide-by-zero) or take mthi/mtlo while idle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (commit) begin
      if (!temp_div0) begin
        hi_q <= temp_hi;
        lo_q <= temp_lo;
      end
    end else if (idle && !bus.flush) begin
      if (bus.op == MDU_MTHI) hi_q <= bus.rs_val;
      if (bus.op == MDU_MTLO) lo_q <= bus.rs_val;
    end
  end
  assign bus.busy   = ~idle;
  assign bus.stall  = bus.d_md_use & (~idle | (bus.start & ~bus.flush));
  assign bus.mf_out = bus.op == MDU_MFHI ? hi_q : bus.op == MDU_MFLO ? lo_q : '0;
  assign bus.hi     = hi_q;
  assign bus.lo     = lo_q;
endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: table-driven, directed and randomized checks of mdu_ctrl
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int tests = 0;
  int fails = 0;
  logic [31:0] m_hi = '0, m_lo = '0;
  mdu_ctrl_if #(.WIDTH(32)) bus ();
  mdu_ctrl #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [31:0] rs, rt;
    int          cycles;
    logic [31:0] ehi, elo;
  } vec_t;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // starts at a negedge, returns at the negedge where busy has dropped
  task automatic run_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt, output int n);
    bus.start = 1'b1; bus.op = op; bus.rs_val = rs; bus.rt_val = rt;
    @(negedge clk);
    bus.start = 1'b0; bus.op = MDU_NOP;
    n = 0;
    while (bus.busy && n < 40) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic mt(input logic [3:0] op, input logic [31:0] v);
    bus.op = op; bus.rs_val = v;
    @(negedge clk);
    bus.op = MDU_NOP;
  endtask

  // reference: architectural result of an MDU op from plain 64-bit arithmetic
  task automatic model(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt);
    longint p, q, r;
    logic [63:0] pv;
    if (op == MDU_MULT) begin
      p = longint'($signed(rs)) * longint'($signed(rt)); pv = p;
      m_hi = pv[63:32]; m_lo = pv[31:0];
    end else if (op == MDU_MULTU) begin
      pv = {32'b0, rs} * {32'b0, rt};
      m_hi = pv[63:32]; m_lo = pv[31:0];
    end else if (rt != 0) begin
      if (op == MDU_DIV) begin
        q = longint'($signed(rs)) / longint'($signed(rt));
        r = longint'($signed(rs)) - q * longint'($signed(rt));
      end else begin
        q = longint'({32'b0, rs}) / longint'({32'b0, rt});
        r = longint'({32'b0, rs}) % longint'({32'b0, rt});
      end
      pv = q; m_lo = pv[31:0];
      pv = r; m_hi = pv[31:0];
    end
  endtask

  initial begin
    vec_t vecs[6];
    int n;
    logic [3:0] rop;
    logic [31:0] rs, rt;
    vecs[0] = '{MDU_MULT,  32'hFFFFFFFE, 32'd3,        5,  32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{MDU_DIVU,  32'd100,      32'd7,        10, 32'd2,        32'd14};
    vecs[2] = '{MDU_DIV,   32'hFFFFFFF9, 32'd2,        10, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[3] = '{MDU_MULTU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE, 32'h00000001};
    vecs[4] = '{MDU_DIV,   32'd7,        32'hFFFFFFFE, 10, 32'd1,        32'hFFFFFFFD};
    vecs[5] = '{MDU_MULT,  32'h80000000, 32'h80000000, 5,  32'h40000000, 32'h00000000};
    bus.start = 0; bus.op = MDU_NOP; bus.rs_val = 0; bus.rt_val = 0; bus.flush = 0; bus.d_md_use = 0;
    repeat (2) @(negedge clk);
    chk("reset_busy", 64'(bus.busy), 0);
    chk("reset_stall", 64'(bus.stall), 0);
    chk("reset_hi", 64'(bus.hi), 0);
    chk("reset_lo", 64'(bus.lo), 0);
    reset = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_op(vecs[i].op, vecs[i].rs, vecs[i].rt, n);
      chk($sformatf("vec%0d_cycles", i), 64'(n), 64'(vecs[i].cycles));
      chk($sformatf("vec%0d_hi", i), 64'(bus.hi), 64'(vecs[i].ehi));
      chk($sformatf("vec%0d_lo", i), 64'(bus.lo), 64'(vecs[i].elo));
      bus.op = MDU_MFLO; #1;
      chk($sformatf("vec%0d_mflo", i), 64'(bus.mf_out), 64'(vecs[i].elo));
      bus.op = MDU_MFHI; #1;
      chk($sformatf("vec%0d_mfhi", i), 64'(bus.mf_out), 64'(vecs[i].ehi));
      bus.op = MDU_NOP;
      m_hi = vecs[i].ehi; m_lo = vecs[i].elo;
    end

    // stall spans the accept cycle plus every busy cycle
    bus.start = 1; bus.op = MDU_DIVU; bus.rs_val = 100; bus.rt_val = 7; bus.d_md_use = 1;
    n = 0;
    for (int i = 0; i < 30; i++) begin
      #1;
      if (!bus.stall) break;
      n++;
      @(negedge clk);
      bus.start = 0; bus.op = MDU_NOP;
    end
    bus.d_md_use = 0;
    chk("stall_cycles", 64'(n), 11);
    chk("stall_lo", 64'(bus.lo), 14);
    chk("stall_hi", 64'(bus.hi), 2);
    m_hi = 2; m_lo = 14;

    // mthi suppressed by flush, then taken
    bus.flush = 1;
    mt(MDU_MTHI, 32'hA5A5A5A5);
    bus.flush = 0;
    chk("mthi_flush", 64'(bus.hi), 64'(m_hi));
    mt(MDU_MTHI, 32'hA5A5A5A5);
    chk("mthi", 64'(bus.hi), 64'hA5A5A5A5);
    m_hi = 32'hA5A5A5A5;

    // start cancelled by flush
    bus.start = 1; bus.op = MDU_MULT; bus.rs_val = 9; bus.rt_val = 9; bus.flush = 1; bus.d_md_use = 1;
    #1;
    chk("flush_start_stall", 64'(bus.stall), 0);
    @(negedge clk);
    bus.start = 0; bus.op = MDU_NOP; bus.flush = 0; bus.d_md_use = 0;
    chk("flush_start_busy", 64'(bus.busy), 0);
    chk("flush_start_hi", 64'(bus.hi), 64'(m_hi));
    chk("flush_start_lo", 64'(bus.lo), 64'(m_lo));

    // flush during a running mult does not cancel it
    bus.start = 1; bus.op = MDU_MULT; bus.rs_val = 6; bus.rt_val = 7;
    @(negedge clk);
    bus.start = 0; bus.op = MDU_NOP;
    repeat (2) @(negedge clk);
    bus.flush = 1;
    @(negedge clk);
    bus.flush = 0;
    n = 0;
    while (bus.busy && n < 40) begin n++; @(negedge clk); end
    chk("flush_mid_remaining", 64'(n), 2);
    chk("flush_mid_hi", 64'(bus.hi), 0);
    chk("flush_mid_lo", 64'(bus.lo), 42);

    // divide by zero leaves HI/LO untouched
    mt(MDU_MTHI, 32'h1234);
    mt(MDU_MTLO, 32'h1234);
    run_op(MDU_DIV, 32'd55, 32'd0, n);
    chk("div0_cycles", 64'(n), 10);
    chk("div0_hi", 64'(bus.hi), 64'h1234);
    chk("div0_lo", 64'(bus.lo), 64'h1234);

    // asynchronous reset mid-divide
    bus.start = 1; bus.op = MDU_DIVU; bus.rs_val = 100; bus.rt_val = 7;
    @(negedge clk);
    bus.start = 0; bus.op = MDU_NOP;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("areset_busy", 64'(bus.busy), 0);
    chk("areset_hi", 64'(bus.hi), 0);
    chk("areset_lo", 64'(bus.lo), 0);
    @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    chk("areset_nocommit_busy", 64'(bus.busy), 0);
    chk("areset_nocommit_lo", 64'(bus.lo), 0);
    m_hi = 0; m_lo = 0;

    // randomized operations against the arithmetic model
    for (int i = 0; i < 24; i++) begin
      rop = 4'($urandom_range(1, 4));
      rs = $urandom;
      rt = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rt = 32'($urandom_range(1, 20));
      model(rop, rs, rt);
      run_op(rop, rs, rt, n);
      chk($sformatf("rnd%0d_cycles", i), 64'(n), is_mul(rop) ? 5 : 10);
      chk($sformatf("rnd%0d_hi", i), 64'(bus.hi), 64'(m_hi));
      chk($sformatf("rnd%0d_lo", i), 64'(bus.lo), 64'(m_lo));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Sequencing controller for the multiply/divide resource in the E stage of the 5-stage MIPS pipeline.
- Accepts the decoder's MDU start/op strobes, latches operands and runs a fixed-latency busy counter. Commits results to the architectural HI/LO registers.
- Generates the D-stage stall for MDU-dependent instructions.
- Honours the exception/interrupt flush so that a cancelled instruction never modifies HI/LO.

Parameters:
- WIDTH, 32, operand and HI/LO width
- MULT_CYCLES, 5, busy cycles for mult/multu (legal range 1..15)
- DIV_CYCLES, 10, busy cycles for div/divu (legal range 1..15)

Ports:
- clk  in  1  system clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  E-stage MDUstart (mult/multu/div/divu)
- op  in  4  E-stage MDUop
- rs_val  in  WIDTH  forwarded E-stage rs operand
- rt_val  in  WIDTH  forwarded E-stage rt operand
- flush  in  1  exception/interrupt request this cycle; cancels E-stage MDU effects
- d_md_use  in  1  D-stage instruction is md/mf/mt class
- busy  out  1  operation in flight
- stall  out  1  D-stage stall request
- mf_out  out  WIDTH  mfhi/mflo read value for the E→M pipeline register
- hi  out  WIDTH  architectural HI
- lo  out  WIDTH  architectural LO

Behaviour:
- Reset (asynchronous, reset==0):
  - state=IDLE; cnt=0; busy=0; hi=lo=0; temp_hi=temp_lo=0.
  - An in-flight operation is aborted and its result discarded.
- States:
  - IDLE → MUL on an accepted start with op mult/multu.
  - IDLE → DIV on an accepted start with op div/divu.
  - MUL/DIV → IDLE when cnt==1 at a clock edge.
- Accepted start:
  - Condition: start & !flush & state==IDLE.
  - At that edge, temp_hi/temp_lo are computed from rs_val and rt_val and latched:
    - mult: signed 64-bit product; hi=upper, lo=lower.
    - multu: unsigned 64-bit product; hi=upper, lo=lower.
    - div/divu: lo=quotient, hi=remainder, signed or unsigned respectively; signed remainder takes the sign of the dividend.
  - cnt is loaded with MULT_CYCLES or DIV_CYCLES.
- Latency:
  - Edge t0 accepts; busy=1 for cycles t0+1 .. t0+N.
  - hi/lo are written from temp at edge t0+N; busy=0 from that edge.
  - An mf issued after the stall releases reads the new value.
- Division by zero: the operation runs the full DIV_CYCLES, but hi/lo are left unchanged at commit.
- mthi/mtlo:
  - When state==IDLE and !flush, hi (or lo) takes rs_val at the edge.
  - Ignored while busy; the stall guarantees this case does not occur legally.
- mfhi/mflo: mf_out is combinational hi or lo as selected by op; 0 for any other op.
- stall = d_md_use & (busy | (start & !flush)), combinational.
- start while busy is ignored (cnt and temp unaffected); by construction the stall prevents this.
- flush:
  - Suppresses start and mt in the same cycle.
  - Does NOT abort an operation accepted on an earlier edge; that instruction has already retired past E.
- Unknown op values are no-ops.
- cnt never wraps: it only decrements in MUL/DIV and is reloaded only in IDLE.

Decomposition:
- MDU_mult/MDU_multu/MDU_div/MDU_divu/MDU_mfhi/MDU_mflo/MDU_mthi/MDU_mtlo 4-bit op codes live in the shared const.v.
- MDU_MULT_CYCLES/MDU_DIV_CYCLES defaults are also defined in const.v.
- The FSM, counter and HI/LO registers stay in mdu_ctrl.
- The signed/unsigned multiply/divide datapath is a natural combinational sub-module, mdu_arith (inputs op, a, b; outputs res_hi, res_lo, div0).

Test Plan:
- mult, rs=0xFFFFFFFE (-2), rt=3 → busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; mflo returns 0xFFFFFFFA.
- divu, rs=100, rt=7 with d_md_use=1 every cycle → stall high 11 cycles (accept cycle + 10 busy); then lo=14, hi=2.
- div, rs=-7, rt=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; div by 0 with prior hi=lo=0x1234 → unchanged after 10 cycles.
- mthi rs=0xA5A5A5A5 with flush=1 → hi unchanged; repeat with flush=0 → hi=0xA5A5A5A5 next edge.
- start=1 with flush=1 → busy stays 0, stall=0, hi/lo unchanged; flush raised at cycle 3 of a running mult → result still committed at cycle 5.
- Assert reset low at cycle 3 of a div → busy=0, hi=lo=0 immediately (asynchronous); no commit afterwards.
